// File: rtl/fft_axil_cfg_regs_if.sv
// AXI4-Lite bus bundle between the host interconnect and the FFT configuration register file.
interface fft_axil_cfg_regs_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/fft_axil_cfg_regs.sv
// AXI4-Lite configuration/status register file in front of the FFT core: buffer descriptors,
// transform options, start pulse generation, busy/done tracking and the level interrupt.
module fft_axil_cfg_regs #(
   parameter int AXIL_DATA_WIDTH = 64,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int TOP_LEN_WIDTH   = 20,
   parameter int NUM_REGISTER    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   fft_axil_cfg_regs_if.slave       s_axil,
   output logic [31:0]              cfg_src_addr,
   output logic [TOP_LEN_WIDTH-1:0] cfg_src_len,
   output logic [31:0]              cfg_dst_addr,
   output logic [TOP_LEN_WIDTH-1:0] cfg_dst_len,
   output logic                     cfg_inverse,
   output logic [3:0]               cfg_log2n,
   output logic                     core_start,
   input  logic                     core_done,
   output logic                     interrupt_out
);
   localparam int STRB_WIDTH = AXIL_DATA_WIDTH / 8;
   localparam logic [3:0] IDX_CTRL   = 4'd0;
   localparam logic [3:0] IDX_SRC    = 4'd1;
   localparam logic [3:0] IDX_DST    = 4'd2;
   localparam logic [3:0] IDX_CFG    = 4'd3;
   localparam logic [3:0] IDX_IRQCLR = 4'd4;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [NUM_REGISTER-1:0][AXIL_DATA_WIDTH-1:0] reg_img_t;

   // Write channel state
   logic                       aw_hold, w_hold, bvalid_q;
   logic [1:0]                 bresp_q;
   logic [3:0]                 aw_idx_q;
   logic [AXIL_DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0]      w_strb_q;
   // Read channel state
   logic                       rvalid_q;
   logic [1:0]                 rresp_q;
   logic [AXIL_DATA_WIDTH-1:0] rdata_q;
   // Register contents and status
   logic [31:0]                src_addr_q, dst_addr_q;
   logic [TOP_LEN_WIDTH-1:0]   src_len_q, dst_len_q;
   logic [3:0]                 log2n_q;
   logic                       inverse_q, busy_q, irq_q, core_start_q;

   logic                       aw_fire, w_fire, commit, wr_idx_ok, ar_fire, rd_idx_ok;
   logic                       start_cmd, clr_cmd, irqclr_cmd, start_ok, unused_bits;
   logic [3:0]                 wr_idx, rd_idx;
   logic [STRB_WIDTH-1:0]      wr_strb;
   logic [AXIL_DATA_WIDTH-1:0] wr_data, wr_mask, wr_merged;
   reg_img_t                   reg_img;

   function automatic logic [AXIL_DATA_WIDTH-1:0] sel_reg(input logic [3:0] idx, input reg_img_t img);
      sel_reg = '0;
      for (int i = 0; i < NUM_REGISTER; i++)
         if (idx == 4'(i)) sel_reg = img[i];
   endfunction

   // Read-back images; bits with no storage read as zero
   assign reg_img = {{63'b0, irq_q},
                     {59'b0, log2n_q, inverse_q},
                     {dst_addr_q, {(32 - TOP_LEN_WIDTH){1'b0}}, dst_len_q},
                     {src_addr_q, {(32 - TOP_LEN_WIDTH){1'b0}}, src_len_q},
                     {62'b0, busy_q, irq_q}};

   // A write commits on the edge where its last half (AW or W) is accepted
   assign aw_fire   = s_axil.awvalid & ~aw_hold;
   assign w_fire    = s_axil.wvalid & ~w_hold;
   assign commit    = (aw_hold | aw_fire) & (w_hold | w_fire) & ~bvalid_q;
   assign wr_idx    = aw_hold ? aw_idx_q : s_axil.awaddr[6:3];
   assign wr_data   = w_hold ? w_data_q : s_axil.wdata;
   assign wr_strb   = w_hold ? w_strb_q : s_axil.wstrb;
   assign wr_idx_ok = wr_idx < 4'(NUM_REGISTER);

   assign start_cmd  = commit & (wr_idx == IDX_CTRL) & wr_strb[0] & wr_data[1];
   assign clr_cmd    = commit & (wr_idx == IDX_CTRL) & wr_strb[0] & wr_data[0];
   assign irqclr_cmd = commit & (wr_idx == IDX_IRQCLR);
   assign start_ok   = start_cmd & ~busy_q;

   // Merge strobed write bytes over the current register image
   always_comb begin
      // NOTE: every always_comb output gets a default before any loop/branch, so no latch can be inferred.
      wr_mask = '0;
      for (int b = 0; b < STRB_WIDTH; b++) wr_mask[8*b +: 8] = {8{wr_strb[b]}};
      wr_merged = (sel_reg(wr_idx, reg_img) & ~wr_mask) | (wr_data & wr_mask);
   end

   // Write handshake tracking, response generation and configuration register updates
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values regardless of statement order.
      if (rst) begin
         aw_hold    <= 1'b0;
         w_hold     <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         src_addr_q <= '0;
         src_len_q  <= '0;
         dst_addr_q <= '0;
         dst_len_q  <= '0;
         log2n_q    <= '0;
         inverse_q  <= 1'b0;
      end else begin
         if (aw_fire) aw_hold <= 1'b1;
         if (w_fire)  w_hold  <= 1'b1;
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
            case (wr_idx)
               IDX_SRC: begin
                  src_addr_q <= wr_merged[63:32];
                  src_len_q  <= wr_merged[TOP_LEN_WIDTH-1:0];
               end
               IDX_DST: begin
                  dst_addr_q <= wr_merged[63:32];
                  dst_len_q  <= wr_merged[TOP_LEN_WIDTH-1:0];
               end
               IDX_CFG: begin
                  log2n_q   <= wr_merged[4:1];
                  inverse_q <= wr_merged[0];
               end
               default: ;
            endcase
         end else if (bvalid_q && s_axil.bready) begin
            bvalid_q <= 1'b0;
            aw_hold  <= 1'b0;
            w_hold   <= 1'b0;
         end
      end
   end

   // Capture address/data of a half-accepted write until its partner arrives
   always_ff @(posedge clk) begin
      // NOTE: these capture registers are only consumed while their hold flag is set, so they carry no reset.
      if (aw_fire) aw_idx_q <= s_axil.awaddr[6:3];
      if (w_fire) begin
         w_data_q <= s_axil.wdata;
         w_strb_q <= s_axil.wstrb;
      end
   end

   // Busy/irq tracking and the start pulse; core completion outranks any clear
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q       <= 1'b0;
         irq_q        <= 1'b0;
         core_start_q <= 1'b0;
      end else begin
         core_start_q <= start_ok;
         if (core_done)                 irq_q <= 1'b1;
         else if (clr_cmd | irqclr_cmd) irq_q <= 1'b0;
         if (start_ok)                  busy_q <= 1'b1;
         else if (core_done | clr_cmd)  busy_q <= 1'b0;
      end
   end

   assign rd_idx    = s_axil.araddr[6:3];
   assign rd_idx_ok = rd_idx < 4'(NUM_REGISTER);
   assign ar_fire   = s_axil.arvalid & ~rvalid_q;

   // Read channel: register the addressed image on AR handshake, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else if (ar_fire) begin
         rvalid_q <= 1'b1;
         rresp_q  <= rd_idx_ok ? RESP_OKAY : RESP_SLVERR;
         rdata_q  <= sel_reg(rd_idx, reg_img);
      end else if (rvalid_q && s_axil.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s_axil.awready = ~aw_hold;
   assign s_axil.wready  = ~w_hold;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.arready = ~rvalid_q;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;

   assign cfg_src_addr  = src_addr_q;
   assign cfg_src_len   = src_len_q;
   assign cfg_dst_addr  = dst_addr_q;
   assign cfg_dst_len   = dst_len_q;
   assign cfg_inverse   = inverse_q;
   assign cfg_log2n     = log2n_q;
   assign core_start    = core_start_q;
   assign interrupt_out = irq_q;

   // Address bits outside the register index and merged bits without storage are intentionally ignored
   assign unused_bits = ^{s_axil.awaddr[AXIL_ADDR_WIDTH-1:7], s_axil.awaddr[2:0],
                          s_axil.araddr[AXIL_ADDR_WIDTH-1:7], s_axil.araddr[2:0], wr_merged};
endmodule

// File: tb/tb_fft_axil_cfg_regs.sv
// Scoreboard bench for fft_axil_cfg_regs: write/read responses are queued when issued and
// compared when the DUT presents them; configuration and interrupt outputs are checked inline.
module tb_fft_axil_cfg_regs;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic core_done = 1'b0;
   logic [31:0] cfg_src_addr, cfg_dst_addr;
   logic [19:0] cfg_src_len, cfg_dst_len;
   logic        cfg_inverse, core_start, interrupt_out;
   logic [3:0]  cfg_log2n;

   int n_vec = 0;
   int n_err = 0;
   logic [1:0]  bq[$];
   logic [65:0] rq[$];

   always #5 clk = ~clk;

   fft_axil_cfg_regs_if s_axil();

   fft_axil_cfg_regs dut (
      .clk(clk), .rst(rst), .s_axil(s_axil),
      .cfg_src_addr(cfg_src_addr), .cfg_src_len(cfg_src_len),
      .cfg_dst_addr(cfg_dst_addr), .cfg_dst_len(cfg_dst_len),
      .cfg_inverse(cfg_inverse), .cfg_log2n(cfg_log2n),
      .core_start(core_start), .core_done(core_done), .interrupt_out(interrupt_out)
   );

   // Issue one write; w_lead > 0 puts W that many cycles ahead of AW, < 0 puts AW ahead.
   task automatic axi_write(input int idx, input logic [63:0] data, input logic [7:0] strb,
                            input int w_lead, input bit done_at_commit);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int aw_at, w_at, cyc = 0;
      aw_at = (w_lead > 0) ? w_lead : 0;
      w_at  = (w_lead < 0) ? -w_lead : 0;
      bq.push_back((idx < 5) ? 2'b00 : 2'b10);
      s_axil.awaddr = 32'(idx) << 3;
      s_axil.wdata  = data;
      s_axil.wstrb  = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         s_axil.awvalid = !aw_done && (cyc >= aw_at);
         s_axil.wvalid  = !w_done && (cyc >= w_at);
         aw_hs = s_axil.awvalid && s_axil.awready;
         w_hs  = s_axil.wvalid && s_axil.wready;
         core_done = done_at_commit && (aw_done || aw_hs) && (w_done || w_hs);
         @(posedge clk); #1;
         core_done = 1'b0;
         aw_done |= aw_hs;
         w_done  |= w_hs;
         cyc++;
      end
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      n_vec++;
      if (!(aw_done && w_done)) begin
         n_err++;
         $display("FAIL write_handshake idx%0d: aw_done=%0b w_done=%0b, required both 1", idx, aw_done, w_done);
      end else if (s_axil.bvalid !== 1'b1) begin
         n_err++;
         $display("FAIL write_latency idx%0d: bvalid=%0b one cycle after handshake, required 1", idx, s_axil.bvalid);
      end
   endtask

   // Collect the B response, optionally stalling bready for 'hold' cycles first.
   task automatic b_resp(input int hold);
      logic [1:0] exp;
      int cyc = 0;
      while (s_axil.bvalid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      exp = bq.pop_front();
      n_vec++;
      if (s_axil.bvalid !== 1'b1) begin
         n_err++;
         $display("FAIL bvalid_timeout: bvalid=%0b after %0d cycles, required 1", s_axil.bvalid, cyc);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (s_axil.bvalid !== 1'b1 || s_axil.awready !== 1'b0) begin
            n_err++;
            $display("FAIL b_stall cycle %0d: bvalid=%0b awready=%0b, required 1/0", i, s_axil.bvalid, s_axil.awready);
         end
      end
      n_vec++;
      if (s_axil.bresp !== exp) begin
         n_err++;
         $display("FAIL bresp: got %b, required %b", s_axil.bresp, exp);
      end
      s_axil.bready = 1'b1;
      @(posedge clk); #1;
      s_axil.bready = 1'b0;
      n_vec++;
      if (s_axil.bvalid !== 1'b0 || s_axil.awready !== 1'b1 || s_axil.wready !== 1'b1) begin
         n_err++;
         $display("FAIL b_release: bvalid=%0b awready=%0b wready=%0b, required 0/1/1",
                  s_axil.bvalid, s_axil.awready, s_axil.wready);
      end
   endtask

   // Issue one read and compare the returned response/data against the queued expectation.
   task automatic axi_read(input int idx, input logic [63:0] exp_data);
      logic [65:0] exp;
      bit hs = 0;
      int cyc = 0;
      rq.push_back({(idx < 5) ? 2'b00 : 2'b10, (idx < 5) ? exp_data : 64'h0});
      s_axil.araddr  = 32'(idx) << 3;
      s_axil.arvalid = 1'b1;
      while (!hs && cyc < 20) begin
         hs = s_axil.arready;
         @(posedge clk); #1;
         cyc++;
      end
      s_axil.arvalid = 1'b0;
      exp = rq.pop_front();
      n_vec++;
      if (!hs || s_axil.rvalid !== 1'b1) begin
         n_err++;
         $display("FAIL read_latency idx%0d: ar_hs=%0b rvalid=%0b, required 1/1", idx, hs, s_axil.rvalid);
      end else if ({s_axil.rresp, s_axil.rdata} !== exp) begin
         n_err++;
         $display("FAIL read idx%0d: got resp=%b data=%h, required resp=%b data=%h",
                  idx, s_axil.rresp, s_axil.rdata, exp[65:64], exp[63:0]);
      end
      s_axil.rready = 1'b1;
      @(posedge clk); #1;
      s_axil.rready = 1'b0;
      n_vec++;
      if (s_axil.rvalid !== 1'b0 || s_axil.arready !== 1'b1) begin
         n_err++;
         $display("FAIL read_release: rvalid=%0b arready=%0b, required 0/1", s_axil.rvalid, s_axil.arready);
      end
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_vec++;
      if ({interrupt_out, core_start, s_axil.bvalid, s_axil.rvalid} !== 4'b0000 ||
          {s_axil.awready, s_axil.wready, s_axil.arready} !== 3'b111) begin
         n_err++;
         $display("FAIL reset_ctrl: irq=%0b start=%0b bvalid=%0b rvalid=%0b aw/w/ar ready=%0b%0b%0b, required 0000/111",
                  interrupt_out, core_start, s_axil.bvalid, s_axil.rvalid,
                  s_axil.awready, s_axil.wready, s_axil.arready);
      end
      n_vec++;
      if ({cfg_src_addr, cfg_src_len, cfg_dst_addr, cfg_dst_len, cfg_log2n, cfg_inverse} !== '0) begin
         n_err++;
         $display("FAIL reset_cfg: src=%h/%h dst=%h/%h log2n=%h inv=%b, required all 0",
                  cfg_src_addr, cfg_src_len, cfg_dst_addr, cfg_dst_len, cfg_log2n, cfg_inverse);
      end
      for (int i = 0; i < 5; i++) axi_read(i, 64'h0);
   endtask

   task automatic test_src_write();
      axi_write(1, 64'h00000001_00000040, 8'hFF, 0, 0);
      n_vec++;
      if (cfg_src_addr !== 32'h1 || cfg_src_len !== 20'd64) begin
         n_err++;
         $display("FAIL src_cfg: got addr=%h len=%h, required 1/40", cfg_src_addr, cfg_src_len);
      end
      b_resp(0);
      axi_read(1, 64'h00000001_00000040);
      // Upper-half strobes only: address replaced, length untouched
      axi_write(1, 64'hAAAA5555_000ABCDE, 8'hF0, 0, 0);
      b_resp(0);
      n_vec++;
      if (cfg_src_addr !== 32'hAAAA5555 || cfg_src_len !== 20'd64) begin
         n_err++;
         $display("FAIL src_strobe: got addr=%h len=%h, required AAAA5555/40", cfg_src_addr, cfg_src_len);
      end
   endtask

   task automatic test_dst_cfg();
      axi_write(2, 64'hDEADBEEF_FFFFFFFF, 8'hFF, 2, 0);
      n_vec++;
      if (cfg_dst_addr !== 32'hDEADBEEF || cfg_dst_len !== 20'hFFFFF) begin
         n_err++;
         $display("FAIL dst_cfg: got addr=%h len=%h, required DEADBEEF/FFFFF", cfg_dst_addr, cfg_dst_len);
      end
      b_resp(0);
      axi_write(3, 64'h6, 8'hFF, -1, 0);
      n_vec++;
      if (cfg_log2n !== 4'd3 || cfg_inverse !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_reg: got log2n=%0d inv=%b, required 3/0", cfg_log2n, cfg_inverse);
      end
      b_resp(0);
      axi_read(2, 64'hDEADBEEF_000FFFFF);
      axi_read(3, 64'h6);
   endtask

   task automatic test_start();
      axi_write(0, 64'h2, 8'hFF, 0, 0);
      n_vec++;
      if (core_start !== 1'b1) begin
         n_err++;
         $display("FAIL start_pulse: core_start=%b, required 1", core_start);
      end
      b_resp(0);
      n_vec++;
      if (core_start !== 1'b0) begin
         n_err++;
         $display("FAIL start_width: core_start=%b one cycle later, required 0", core_start);
      end
      axi_read(0, 64'h2);
      axi_write(0, 64'h2, 8'hFF, 0, 0);
      n_vec++;
      if (core_start !== 1'b0) begin
         n_err++;
         $display("FAIL start_while_busy: core_start=%b, required 0", core_start);
      end
      b_resp(0);
      pulse_done();
      n_vec++;
      if (interrupt_out !== 1'b1) begin
         n_err++;
         $display("FAIL done_irq: interrupt_out=%b, required 1", interrupt_out);
      end
      axi_read(0, 64'h1);
   endtask

   task automatic test_irqclr();
      axi_write(4, 64'h0, 8'hFF, 0, 0);
      n_vec++;
      if (interrupt_out !== 1'b0) begin
         n_err++;
         $display("FAIL irqclr: interrupt_out=%b after commit, required 0", interrupt_out);
      end
      b_resp(0);
      axi_write(0, 64'h2, 8'h01, 0, 0);
      b_resp(0);
      pulse_done();
      axi_write(4, 64'h0, 8'hFF, 0, 1);
      n_vec++;
      if (interrupt_out !== 1'b1) begin
         n_err++;
         $display("FAIL irqclr_vs_done: interrupt_out=%b, required 1", interrupt_out);
      end
      b_resp(0);
      axi_read(4, 64'h1);
      axi_write(0, 64'h1, 8'hFF, 0, 0);
      b_resp(0);
      n_vec++;
      if (interrupt_out !== 1'b0) begin
         n_err++;
         $display("FAIL soft_clear: interrupt_out=%b, required 0", interrupt_out);
      end
      axi_read(0, 64'h0);
   endtask

   task automatic test_bad_index();
      axi_write(7, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 0);
      b_resp(5);
      axi_read(7, 64'h0);
      axi_read(1, 64'hAAAA5555_00000040);
      axi_read(2, 64'hDEADBEEF_000FFFFF);
      axi_read(3, 64'h6);
   endtask

   task automatic test_reset_mid();
      s_axil.wdata  = 64'h1234;
      s_axil.wstrb  = 8'hFF;
      s_axil.wvalid = 1'b1;
      @(posedge clk); #1;
      s_axil.wvalid = 1'b0;
      n_vec++;
      if (s_axil.wready !== 1'b0) begin
         n_err++;
         $display("FAIL w_latch: wready=%b after W only, required 0", s_axil.wready);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({s_axil.awready, s_axil.wready, s_axil.bvalid, s_axil.rvalid} !== 4'b1100) begin
         n_err++;
         $display("FAIL reset_mid: aw/w ready=%b%b bvalid=%b rvalid=%b, required 11/0/0",
                  s_axil.awready, s_axil.wready, s_axil.bvalid, s_axil.rvalid);
      end
      axi_read(1, 64'h0);
   endtask

   initial begin
      s_axil.awaddr = '0; s_axil.awvalid = 1'b0; s_axil.wdata = '0; s_axil.wstrb = '0;
      s_axil.wvalid = 1'b0; s_axil.bready = 1'b0; s_axil.araddr = '0; s_axil.arvalid = 1'b0;
      s_axil.rready = 1'b0;
      test_reset();
      test_src_write();
      test_dst_cfg();
      test_start();
      test_irqclr();
      test_bad_index();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule

// File: doc/fft_axil_cfg_regs.md
Name: fft_axil_cfg_regs

Overview:
AXI4-Lite slave register file directly upstream of the FFT core. It accepts host configuration of source and destination buffer descriptors, transform options and the start command, and presents them to the core as stable configuration outputs plus a one-cycle start pulse. It also tracks busy/done status and drives the level interrupt, which the host clears through a register write.

Parameters:
AXIL_DATA_WIDTH, 64, data bus width; fixed at 64, no other value supported
AXIL_ADDR_WIDTH, 32, address bus width
TOP_LEN_WIDTH, 20, width of the transfer length fields
NUM_REGISTER, 5, number of implemented registers (indices 0..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axil_awaddr  in  AXIL_ADDR_WIDTH  write address; register index = awaddr[6:3]
s_axil_awvalid/s_axil_awready  in/out  1  write address handshake
s_axil_wdata  in  64  write data
s_axil_wstrb  in  8  byte strobes; only strobed bytes are updated
s_axil_wvalid/s_axil_wready  in/out  1  write data handshake
s_axil_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axil_bvalid/s_axil_bready  out/in  1  write response handshake
s_axil_araddr  in  AXIL_ADDR_WIDTH  read address; index = araddr[6:3]
s_axil_arvalid/s_axil_arready  in/out  1  read address handshake
s_axil_rdata  out  64  read data
s_axil_rresp  out  2  read response
s_axil_rvalid/s_axil_rready  out/in  1  read data handshake
cfg_src_addr/cfg_dst_addr  out  32  buffer base addresses
cfg_src_len/cfg_dst_len  out  TOP_LEN_WIDTH  lengths in 64-bit words
cfg_inverse  out  1  selects inverse transform
cfg_log2n  out  4  log2 of the transform size
core_start  out  1  single-cycle start pulse to the core
core_done  in  1  single-cycle completion pulse from the core
interrupt_out  out  1  level interrupt

Behaviour:
- Register map:
  - Idx0 CTRL. Write: bit1 = start, bit0 = soft clear of busy/irq. Read: {62'b0, busy, irq}.
  - Idx1 SRC: [63:32] = addr, [TOP_LEN_WIDTH-1:0] = len.
  - Idx2 DST: same layout as SRC.
  - Idx3 CFG: [4:1] = log2n, [0] = inverse.
  - Idx4 IRQCLR. A write of any value clears irq. Read returns {63'b0, irq}.
- Unused bits read as 0. Index 5..15: write is discarded with bresp=10; read returns rdata=0 with rresp=10.
- Reset: all registers 0, busy=0, irq=0, interrupt_out=0, core_start=0, bvalid=0, rvalid=0, awready=1, wready=1, arready=1, bresp=rresp=00, rdata=0.
- Write path:
  - The AW and W channels are captured independently, in the same cycle or in different cycles, and in either order.
  - awready drops once an address is latched; wready drops once data is latched. Both return high after the B handshake.
  - The register update happens in the cycle after both are latched. bvalid rises in that same cycle and holds until bready.
  - Latency from final AW/W handshake to bvalid is 1 cycle. Only one write is outstanding at a time.
- Read path:
  - arready=1 while rvalid=0. On AR handshake, rdata/rresp are registered and rvalid rises the next cycle.
  - rvalid holds until rready; arready=0 meanwhile.
  - Reads and writes are fully independent and may complete in the same cycle.
- Start:
  - A CTRL write with bit1=1 while busy=0 causes core_start=1 in the cycle after the write commits, and sets busy.
  - The start bit is self-clearing.
  - A start while busy=1 is ignored, bresp stays OKAY, and core_start is not pulsed.
- Done: core_done sets irq and clears busy on the next edge. interrupt_out equals irq (registered).
- Simultaneous events:
  - core_done in the same cycle as an IRQCLR commit: set wins, irq stays 1.
  - A CTRL bit0 clear in the same cycle as core_done: set wins.
- Stability: cfg_* outputs reflect register contents continuously. SRC/DST/CFG writes while busy are accepted and take effect immediately; software must not issue them.
- Reset mid-transaction drops pending AW/W latches, bvalid and rvalid; no response is issued.

Test Plan:
- Reset, then read idx0..4 -> rdata=0, rresp=00 for each; interrupt_out=0; awready, wready and arready all 1.
- Write idx1=0x00000001_00000040 with AW and W in the same cycle -> bvalid 1 cycle later, bresp=00; cfg_src_addr=1, cfg_src_len=64; read-back matches.
- Write idx2 with W two cycles before AW, then idx3=0x6 -> cfg_dst_* updated after the AW handshake; cfg_log2n=3, cfg_inverse=0.
- Write CTRL=0x2 -> core_start high exactly 1 cycle, busy read as 1; second CTRL=0x2 -> no pulse; core_done pulse -> interrupt_out=1, CTRL reads 0x1.
- Write idx4=0 -> interrupt_out falls the cycle after commit. Repeat with core_done coinciding with the commit -> interrupt_out stays 1.
- Write/read idx7 -> bresp=10, rresp=10, rdata=0, no register changed. Hold bready=0 for 5 cycles -> bvalid held and awready stays 0.
